// File: rtl/crc_check_ctrl.sv
// CRC-6 pair checker with bounded retransmission, pass/fail verdict handshake,
// saturating error count and a sticky consecutive-failure alarm.
module crc_check_ctrl #(
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned ALARM_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [7:0]       in_crc,
    output logic             retry_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_ok,
    output logic             alarm,
    input  logic             alarm_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam int unsigned FW = $clog2(ALARM_THRESH + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [FW-1:0] FAIL_LIMIT  = FW'(ALARM_THRESH);

    typedef enum logic [1:0] {StIdle, StCheck, StRetry, StReport} state_e;

    state_e           state_q, state_d;
    logic             run_q;
    logic [7:0]       data_q, data_d;
    logic [5:0]       crc_q, crc_d;
    logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [FW-1:0]    consec_q, consec_d, consec_base;
    logic             alarm_q, alarm_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic accept, match, fail_hs, pass_hs;

    // Expected CRC with the fixed seed already folded into the equations.
    function automatic logic [5:0] crc6(input logic [7:0] d);
        logic [5:0] n;
        n[0] = d[5] ^ d[2] ^ d[1] ^ d[0] ^ 1'b1;
        n[1] = d[6] ^ d[5] ^ d[3] ^ d[0];
        n[2] = d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0];
        n[3] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0];
        n[4] = d[7] ^ d[4] ^ d[3] ^ d[1] ^ 1'b1;
        n[5] = d[4] ^ d[1] ^ d[0] ^ 1'b1;
        return n;
    endfunction

    assign match   = (crc6(data_q) == crc_q);
    assign accept  = in_valid && in_ready;
    assign fail_hs = (state_q == StReport) && out_ready && !match;
    assign pass_hs = (state_q == StReport) && out_ready && match;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StCheck;
            StCheck:  state_d = (match || retry_cnt_q == RETRY_LIMIT) ? StReport : StRetry;
            StRetry:  if (accept) state_d = StCheck;
            StReport: if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs; run_q keeps in_ready low while reset is held
    always_comb begin
        in_ready  = run_q && (state_q == StIdle || state_q == StRetry);
        retry_req = (state_q == StRetry);
        out_valid = (state_q == StReport);
        out_data  = out_valid ? data_q : 8'h00;
        out_ok    = out_valid && match;
        alarm     = alarm_q;
        err_cnt   = err_q;
    end

    // Capture and retry counting
    always_comb begin
        data_d      = data_q;
        crc_d       = crc_q;
        retry_cnt_d = retry_cnt_q;
        if (accept) begin
            data_d      = in_data;
            crc_d       = in_crc[5:0];
            retry_cnt_d = (state_q == StRetry) ? retry_cnt_q + RW'(1) : '0;
        end
    end

    // Statistics; a clear in the same cycle as a FAIL handshake is applied first
    always_comb begin
        consec_base = alarm_clr ? '0 : consec_q;
        consec_d    = consec_base;
        alarm_d     = alarm_clr ? 1'b0 : alarm_q;
        err_d       = err_q;
        if (fail_hs) begin
            if (consec_base != FAIL_LIMIT) consec_d = consec_base + FW'(1);
            if (err_q != '1) err_d = err_q + CNT_W'(1);
        end else if (pass_hs) begin
            consec_d = '0;
        end
        if (fail_hs && consec_d == FAIL_LIMIT) alarm_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            data_q      <= '0;
            crc_q       <= '0;
            retry_cnt_q <= '0;
            consec_q    <= '0;
            alarm_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            run_q       <= 1'b1;
            data_q      <= data_d;
            crc_q       <= crc_d;
            retry_cnt_q <= retry_cnt_d;
            consec_q    <= consec_d;
            alarm_q     <= alarm_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_check_ctrl.sv
// Scenario-driven bench for crc_check_ctrl; expected verdicts travel through a
// scoreboard queue pushed at stimulus time and popped at the verdict.
module tb_crc_check_ctrl;

    localparam int unsigned MAX_RETRY    = 2;
    localparam int unsigned ALARM_THRESH = 4;
    localparam int unsigned CNT_W        = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic [7:0]       in_crc = 8'h00;
    logic             retry_req;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_ok;
    logic             alarm;
    logic             alarm_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    crc_check_ctrl #(
        .MAX_RETRY   (MAX_RETRY),
        .ALARM_THRESH(ALARM_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_crc   (in_crc),
        .retry_req(retry_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ok   (out_ok),
        .alarm    (alarm),
        .alarm_clr(alarm_clr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int retry_eps = 0;
    int exp_err = 0;
    logic retry_prev = 1'b0;
    logic [8:0] sb[$];  // {data, ok}

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (retry_req && !retry_prev) retry_eps++;
        retry_prev = retry_req;
    end

    function automatic logic [5:0] crc_model(input logic [7:0] d);
        logic [5:0] n;
        n[0] = ~(d[5] ^ d[2] ^ d[1] ^ d[0]);
        n[1] = d[6] ^ d[5] ^ d[3] ^ d[0];
        n[2] = d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0];
        n[3] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0];
        n[4] = ~(d[7] ^ d[4] ^ d[3] ^ d[1]);
        n[5] = ~(d[4] ^ d[1] ^ d[0]);
        return n;
    endfunction

    // Present a pair until accepted; a lost handshake counts as a failure.
    task automatic send(input logic [7:0] d, input logic [7:0] c, output int hs_cyc);
        bit to = 1'b1;
        in_data  = d;
        in_crc   = c;
        in_valid = 1'b1;
        hs_cyc   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                hs_cyc = cyc;
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL send_timeout: data %h not accepted within 100 cycles", d);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid at a negedge; n = negedges waited.
    task automatic wait_out(output int n);
        bit to = 1'b1;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL verdict_timeout: out_valid absent for 100 cycles");
        end
    endtask

    // Pop the expected verdict and compare it with the DUT outputs.
    task automatic check_verdict(input string name);
        logic [8:0] e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: verdict %h/%b with empty scoreboard", name, out_data, out_ok);
        end else begin
            e = sb.pop_front();
            if ({out_data, out_ok} !== e) begin
                n_fail++;
                $display("FAIL %s: got data %h ok %b want data %h ok %b",
                         name, out_data, out_ok, e[8:1], e[0]);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        alarm_clr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        exp_err = 0;
    endtask

    // Same corrupted pair sent until retries are exhausted.
    task automatic fail_frame(input logic [7:0] d);
        int hs;
        sb.push_back({d, 1'b0});
        for (int i = 0; i <= int'(MAX_RETRY); i++) send(d, {2'b00, crc_model(d) ^ 6'h2a}, hs);
        exp_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, retry_req, out_valid, out_ok, alarm} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {in_ready, retry_req, out_valid, out_ok, alarm});
        end
        n_cmp++;
        if (out_data !== 8'h00 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got data %h err %0d want 00 / 0", out_data, err_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_pass_latency();
        int hs, n;
        retry_eps = 0;
        sb.push_back({8'h00, 1'b1});
        send(8'h00, 8'h31, hs);
        wait_out(n);
        n_cmp++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL pass_latency: got %0d cycles want 2", n);
        end
        check_verdict("pass_00");
        @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 8'd0 || retry_eps != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_side: got err %0d retries %0d out_valid %b want 0 0 0",
                     err_cnt, retry_eps, out_valid);
        end
    endtask

    task automatic test_upper_bits();
        int hs, n;
        sb.push_back({8'hFF, 1'b1});
        send(8'hFF, 8'hD9, hs);
        wait_out(n);
        check_verdict("upper_crc_bits");
    endtask

    task automatic test_retry_recover();
        int hs, n;
        bit got = 1'b0;
        retry_eps = 0;
        send(8'hFF, 8'h00, hs);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (retry_req) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL retry_req_raise: got 0 want 1 after bad CRC");
        end
        sb.push_back({8'hFF, 1'b1});
        send(8'hFF, 8'h19, hs);
        wait_out(n);
        check_verdict("retry_recover");
        @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 8'd0 || retry_eps != 1) begin
            n_fail++;
            $display("FAIL retry_recover_side: got err %0d episodes %0d want 0 1",
                     err_cnt, retry_eps);
        end
    endtask

    task automatic test_retry_exhaust();
        int hs, n;
        retry_eps = 0;
        sb.push_back({8'h00, 1'b0});
        for (int i = 0; i < 3; i++) send(8'h00, 8'h00, hs);
        exp_err++;
        wait_out(n);
        check_verdict("retry_exhaust");
        @(posedge clk);
        #1;
        n_cmp++;
        if (retry_eps != int'(MAX_RETRY) || err_cnt !== CNT_W'(exp_err)) begin
            n_fail++;
            $display("FAIL retry_exhaust_side: got episodes %0d err %0d want %0d %0d",
                     retry_eps, err_cnt, MAX_RETRY, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        int hs[3];
        logic [7:0] d[3];
        d[0] = 8'h12; d[1] = 8'hA7; d[2] = 8'h5E;
        for (int i = 0; i < 3; i++) sb.push_back({d[i], 1'b1});
        fork
            begin
                for (int i = 0; i < 3; i++) send(d[i], {2'b01, crc_model(d[i])}, hs[i]);
            end
            begin
                int n;
                for (int i = 0; i < 3; i++) begin
                    wait_out(n);
                    check_verdict("back_to_back");
                end
            end
        join
        n_cmp++;
        if (hs[1] - hs[0] != 3 || hs[2] - hs[1] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d,%0d cycles want 3,3",
                     hs[1] - hs[0], hs[2] - hs[1]);
        end
    endtask

    task automatic test_alarm();
        int hs, n;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fail_frame(8'(k * 37 + 1));
            wait_out(n);
            check_verdict("alarm_fail");
            @(posedge clk);
            #1;
            n_cmp++;
            if (alarm !== (k == 3)) begin
                n_fail++;
                $display("FAIL alarm_build_%0d: got %b want %b", k, alarm, k == 3);
            end
        end
        sb.push_back({8'h3C, 1'b1});
        send(8'h3C, {2'b10, crc_model(8'h3C)}, hs);
        wait_out(n);
        check_verdict("alarm_pass");
        @(posedge clk);
        #1;
        n_cmp++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_sticky: got %b want 1", alarm);
        end
        alarm_clr = 1'b1;
        @(posedge clk);
        #1 alarm_clr = 1'b0;
        n_cmp++;
        if (alarm !== 1'b0 || err_cnt !== CNT_W'(exp_err)) begin
            n_fail++;
            $display("FAIL alarm_clear: got alarm %b err %0d want 0 %0d", alarm, err_cnt, exp_err);
        end
        // Three fails, then a fourth whose handshake coincides with a clear.
        for (int k = 0; k < 4; k++) begin
            fail_frame(8'(k + 8'h80));
            wait_out(n);
            check_verdict("clr_fail");
            if (k == 3) alarm_clr = 1'b1;
            @(posedge clk);
            #1 alarm_clr = 1'b0;
        end
        n_cmp++;
        if (alarm !== 1'b0 || err_cnt !== CNT_W'(exp_err)) begin
            n_fail++;
            $display("FAIL clr_coincident: got alarm %b err %0d want 0 %0d",
                     alarm, err_cnt, exp_err);
        end
        // That coincident FAIL counted as one, so three more reach the threshold.
        for (int k = 0; k < 3; k++) begin
            fail_frame(8'(k + 8'hC0));
            wait_out(n);
            check_verdict("post_clr_fail");
            @(posedge clk);
            #1;
            n_cmp++;
            if (alarm !== (k == 2)) begin
                n_fail++;
                $display("FAIL post_clr_alarm_%0d: got %b want %b", k, alarm, k == 2);
            end
        end
    endtask

    task automatic test_backpressure_reset();
        int hs, n;
        apply_reset();
        out_ready = 1'b1;
        fail_frame(8'h77);
        wait_out(n);
        check_verdict("bp_prefail");
        @(posedge clk);
        #1 out_ready = 1'b0;
        sb.push_back({8'h5A, 1'b1});
        send(8'h5A, {2'b00, crc_model(8'h5A)}, hs);
        wait_out(n);
        check_verdict("bp_verdict");
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_crc   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if ({out_valid, out_data, out_ok, in_ready} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v %b d %h ok %b rdy %b want 1 5a 1 0",
                         i, out_valid, out_data, out_ok, in_ready);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, retry_req, out_valid, out_ok, alarm} !== 5'b0 ||
            out_data !== 8'h00 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL bp_reset: got flags %b data %h err %0d want 00000 00 0",
                     {in_ready, retry_req, out_valid, out_ok, alarm}, out_data, err_cnt);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_verdict: got out_valid %b want 0", out_valid);
        end
        sb.delete();
        sb.push_back({8'hE4, 1'b1});
        send(8'hE4, {2'b11, crc_model(8'hE4)}, hs);
        wait_out(n);
        check_verdict("bp_recover");
    endtask

    initial begin
        test_reset();
        test_pass_latency();
        test_upper_bits();
        test_retry_recover();
        test_retry_exhaust();
        test_back_to_back();
        test_alarm();
        test_backpressure_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_check_ctrl.md
Name: crc_check_ctrl

Overview:
Sequencing controller around the CRC-6 byte checker. It accepts {data, crc} pairs over a valid/ready handshake and checks each one with the fixed-seed CRC-6 function. On a mismatch it requests retransmission up to a bounded retry count. It then reports a pass/fail verdict downstream, keeps error statistics, and raises a sticky alarm after too many consecutive failed frames. It sits between the link receiver and the consumer of checked bytes.

Parameters:
MAX_RETRY, 2, retransmissions requested per frame before a FAIL verdict (0 = never retry)
ALARM_THRESH, 4, consecutive FAIL verdicts that set alarm (>=1)
CNT_W, 8, width of err_cnt (saturating)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  {in_data, in_crc} valid
in_ready  out  1  controller can accept a pair
in_data  in  8  payload byte
in_crc  in  8  received CRC; only [5:0] compared, [7:6] ignored
retry_req  out  1  request sender to resend current byte
out_valid  out  1  verdict valid
out_ready  in  1  consumer accepts verdict
out_data  out  8  checked byte
out_ok  out  1  1 = CRC match, 0 = FAIL after retries exhausted
alarm  out  1  sticky alarm
alarm_clr  in  1  clears alarm and consecutive-fail counter
err_cnt  out  CNT_W  total FAIL verdicts, saturating at all-ones

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, retry_req=0, out_valid=0, out_ok=0, out_data=0, alarm=0, err_cnt=0; retry and consecutive-fail counters =0. in_ready rises the first cycle after reset deasserts.
- CRC function, with seed c=6'b110111 folded in (n = expected CRC, ^ = xor):
  n0=d5^d2^d1^d0^1; n1=d6^d5^d3^d0; n2=d7^d6^d5^d4^d2^d0; n3=d7^d6^d3^d2^d0; n4=d7^d4^d3^d1^1; n5=d4^d1^d0^1.
  Match iff n == in_crc[5:0] of the captured pair.
- States: IDLE, CHECK, RETRY, REPORT.
- IDLE: in_ready=1. On in_valid&in_ready, capture data and crc into registers; retry_cnt=0; go to CHECK.
- CHECK (1 cycle, in_ready=0): compare captured pair.
  - match: go to REPORT with ok=1.
  - mismatch and retry_cnt<MAX_RETRY: go to RETRY.
  - mismatch and retry_cnt==MAX_RETRY: go to REPORT with ok=0.
- RETRY: retry_req=1 and in_ready=1 until a handshake. On handshake, recapture, retry_cnt++, go to CHECK. retry_req drops the cycle after the handshake.
- REPORT: out_valid=1. out_data and out_ok are held stable until out_ready. On handshake:
  - ok=1: consec_fail=0.
  - ok=0: consec_fail++ (saturating at ALARM_THRESH); err_cnt++ (saturating).
  - Either way go to IDLE; out_valid drops the next cycle.
- Latency: accept-to-out_valid is 2 cycles when no retry occurs. Back-to-back throughput is 1 pair per 3 cycles with out_ready held at 1.
- alarm sets on the clock edge where consec_fail reaches ALARM_THRESH. It stays at 1 until alarm_clr and is unaffected by later PASS verdicts.
- alarm_clr (any state, synchronous): alarm=0, consec_fail=0.
  - If a FAIL handshake occurs in the same cycle, clear applies first and that FAIL counts: consec_fail=1, and alarm=1 only if ALARM_THRESH==1.
  - alarm_clr never affects err_cnt.
- in_valid is ignored in CHECK and REPORT. Sender holds data stable while in_valid && !in_ready.
- Reset mid-frame discards the captured byte; no verdict is emitted.

Test Plan:
- Reset then pair d=8'h00, crc=8'h31 with out_ready=1 -> out_valid exactly 2 cycles after accept; out_data=8'h00, out_ok=1, retry_req never asserted, err_cnt=0.
- d=8'hFF, crc=8'hD9 (bits[7:6] set, [5:0]=6'h19) -> out_ok=1, showing upper CRC bits are ignored.
- d=8'hFF, crc=8'h00, then resend d=8'hFF, crc=8'h19 -> retry_req=1 after first CHECK; after the resend, out_ok=1 and err_cnt=0.
- MAX_RETRY=2, same bad pair d=8'h00, crc=8'h00 sent 3 times -> exactly 2 retry_req episodes, then out_ok=0, err_cnt=1.
- Four consecutive FAIL frames -> alarm=1 at the 4th verdict handshake. A following PASS keeps alarm=1. alarm_clr -> alarm=0 next cycle, err_cnt stays 4.
- out_ready held 0 for 5 cycles in REPORT -> out_valid, out_data, out_ok stable and in_ready=0. Assert rst mid-REPORT -> all outputs zero immediately and counters cleared.
